// File: rtl/neuron_buffer_swap_ctrl.sv
// Ping-pong neuron buffer sequencer: grants conv-side reads and pool-side writes per layer,
// then swaps the buffers once both sides of the layer have finished.
module neuron_buffer_swap_ctrl #(
  parameter int A  = 7,
  parameter int LW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [LW-1:0] numLayers,
  input  logic [A:0]    readLen,
  input  logic [A:0]    writeLen,
  input  logic          readReq,
  output logic          rdGrant,
  input  logic          writeEn,
  output logic          wrGrant,
  output logic [A-1:0]  readBuffAddress,
  output logic [A-1:0]  writeBuffAddress,
  output logic          readBufferSelect,
  output logic [LW-1:0] layerIdx,
  output logic          busy,
  output logic          done,
  output logic          cfgErr,
  output logic          wrOverflow,
  output logic [1:0]    o_dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SWAP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [A:0] MAX_LEN = {1'b1, {A{1'b0}}};

  logic [1:0]    r_state;
  logic [LW-1:0] r_num_layers;
  logic [A:0]    r_read_len;
  logic [A:0]    r_write_len;
  logic [A:0]    r_read_cnt;
  logic [A:0]    r_write_cnt;
  logic [LW-1:0] r_layer_idx;
  logic          r_sel;
  logic          r_cfg_err;
  logic          r_wr_ovf;

  logic          w_rd_grant;
  logic          w_wr_grant;
  logic [A:0]    w_read_cnt_nxt;
  logic [A:0]    w_write_cnt_nxt;
  logic          w_cfg_bad;
  logic          w_layer_last;
  logic          w_layer_complete;

  // Handshake: a request (readReq/writeEn) is accepted in the same cycle its grant is high;
  // the matching address is valid in that cycle and the counter advances on the next edge.
  assign w_rd_grant = (r_state == ST_RUN) && readReq && (r_read_cnt < r_read_len);
  assign w_wr_grant = (r_state == ST_RUN) && writeEn && (r_write_cnt < r_write_len);

  assign w_read_cnt_nxt   = r_read_cnt + {{A{1'b0}}, w_rd_grant};
  assign w_write_cnt_nxt  = r_write_cnt + {{A{1'b0}}, w_wr_grant};
  assign w_layer_complete = (w_read_cnt_nxt == r_read_len) && (w_write_cnt_nxt == r_write_len);
  assign w_cfg_bad        = (readLen > MAX_LEN) || (writeLen > MAX_LEN);
  assign w_layer_last     = (r_layer_idx == (r_num_layers - LW'(1)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_num_layers <= '0;
      r_read_len   <= '0;
      r_write_len  <= '0;
      r_read_cnt   <= '0;
      r_write_cnt  <= '0;
      r_layer_idx  <= '0;
      r_sel        <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_wr_ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_cfg_bad) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_num_layers <= numLayers;
              r_read_len   <= readLen;
              r_write_len  <= writeLen;
              r_read_cnt   <= '0;
              r_write_cnt  <= '0;
              r_layer_idx  <= '0;
              r_sel        <= 1'b0;
              r_cfg_err    <= 1'b0;
              r_wr_ovf     <= 1'b0;
              r_state      <= (numLayers == '0) ? ST_DONE : ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_read_cnt  <= w_read_cnt_nxt;
          r_write_cnt <= w_write_cnt_nxt;
          if (writeEn && !w_wr_grant) begin
            r_wr_ovf <= 1'b1;
          end
          if (w_layer_complete) begin
            r_state <= ST_SWAP;
          end
        end
        ST_SWAP: begin
          r_sel       <= ~r_sel;
          r_read_cnt  <= '0;
          r_write_cnt <= '0;
          if (w_layer_last) begin
            r_state <= ST_DONE;
          end else begin
            r_layer_idx <= r_layer_idx + LW'(1);
            r_state     <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Addresses are the low bits of the counters, so a full 2^A layer wraps back to 0.
  assign rdGrant          = w_rd_grant;
  assign wrGrant          = w_wr_grant;
  assign readBuffAddress  = r_read_cnt[A-1:0];
  assign writeBuffAddress = r_write_cnt[A-1:0];
  assign readBufferSelect = r_sel;
  assign layerIdx         = r_layer_idx;
  assign busy             = (r_state != ST_IDLE);
  assign done             = (r_state == ST_DONE);
  assign cfgErr           = r_cfg_err;
  assign wrOverflow       = r_wr_ovf;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_neuron_buffer_swap_ctrl.sv
// Bench for neuron_buffer_swap_ctrl: per-cycle comparison against a layer-level reference model.
module tb_neuron_buffer_swap_ctrl;
  localparam int A     = 7;
  localparam int LW    = 4;
  localparam int DEPTH = 1 << A;

  // Model phases, named after the behaviour they describe.
  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_SWAP = 2;
  localparam int PH_DONE = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [LW-1:0] numLayers;
  logic [A:0]    readLen;
  logic [A:0]    writeLen;
  logic          readReq;
  logic          rdGrant;
  logic          writeEn;
  logic          wrGrant;
  logic [A-1:0]  readBuffAddress;
  logic [A-1:0]  writeBuffAddress;
  logic          readBufferSelect;
  logic [LW-1:0] layerIdx;
  logic          busy;
  logic          done;
  logic          cfgErr;
  logic          wrOverflow;
  logic [1:0]    o_dbg_state;

  neuron_buffer_swap_ctrl #(.A(A), .LW(LW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .numLayers(numLayers),
    .readLen(readLen), .writeLen(writeLen), .readReq(readReq), .rdGrant(rdGrant),
    .writeEn(writeEn), .wrGrant(wrGrant), .readBuffAddress(readBuffAddress),
    .writeBuffAddress(writeBuffAddress), .readBufferSelect(readBufferSelect),
    .layerIdx(layerIdx), .busy(busy), .done(done), .cfgErr(cfgErr),
    .wrOverflow(wrOverflow), .o_dbg_state(o_dbg_state)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_ph, m_nl, m_rl, m_wl, m_rc, m_wc, m_layer;
  bit m_sel, m_cfg, m_ovf;

  // Observations from the most recent cycle
  bit last_done, last_rg, last_wg;

  // Expected read-address sequence for the full-depth layer
  logic [A-1:0] exp_q[$];
  bit track_rd = 0;

  task automatic model_reset();
    m_ph = PH_IDLE; m_nl = 0; m_rl = 0; m_wl = 0; m_rc = 0; m_wc = 0; m_layer = 0;
    m_sel = 0; m_cfg = 0; m_ovf = 0;
  endtask

  // One clock: drive inputs, compare outputs against the model, then advance the model on the edge.
  task automatic cycle(input bit s, input int nl, input int rl, input int wl,
                       input bit rq, input bit we, input string tag);
    bit e_rg, e_wg;
    logic [A-1:0] e_ra, e_wa;
    logic [LW-1:0] e_li;
    start = s; numLayers = nl[LW-1:0]; readLen = rl[A:0]; writeLen = wl[A:0];
    readReq = rq; writeEn = we;
    #1;
    e_rg = (m_ph == PH_RUN) && rq && (m_rc < m_rl);
    e_wg = (m_ph == PH_RUN) && we && (m_wc < m_wl);
    e_ra = A'(m_rc % DEPTH);
    e_wa = A'(m_wc % DEPTH);
    e_li = LW'(m_layer);
    n_tests++; if (rdGrant !== e_rg) begin n_fail++; $display("FAIL %s rdGrant got %0b exp %0b", tag, rdGrant, e_rg); end
    n_tests++; if (wrGrant !== e_wg) begin n_fail++; $display("FAIL %s wrGrant got %0b exp %0b", tag, wrGrant, e_wg); end
    n_tests++; if (readBuffAddress !== e_ra) begin n_fail++; $display("FAIL %s readBuffAddress got %0d exp %0d", tag, readBuffAddress, e_ra); end
    n_tests++; if (writeBuffAddress !== e_wa) begin n_fail++; $display("FAIL %s writeBuffAddress got %0d exp %0d", tag, writeBuffAddress, e_wa); end
    n_tests++; if (readBufferSelect !== m_sel) begin n_fail++; $display("FAIL %s readBufferSelect got %0b exp %0b", tag, readBufferSelect, m_sel); end
    n_tests++; if (layerIdx !== e_li) begin n_fail++; $display("FAIL %s layerIdx got %0d exp %0d", tag, layerIdx, e_li); end
    n_tests++; if (busy !== (m_ph != PH_IDLE)) begin n_fail++; $display("FAIL %s busy got %0b exp %0b", tag, busy, m_ph != PH_IDLE); end
    n_tests++; if (done !== (m_ph == PH_DONE)) begin n_fail++; $display("FAIL %s done got %0b exp %0b", tag, done, m_ph == PH_DONE); end
    n_tests++; if (cfgErr !== m_cfg) begin n_fail++; $display("FAIL %s cfgErr got %0b exp %0b", tag, cfgErr, m_cfg); end
    n_tests++; if (wrOverflow !== m_ovf) begin n_fail++; $display("FAIL %s wrOverflow got %0b exp %0b", tag, wrOverflow, m_ovf); end
    if (track_rd && rdGrant === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL %s rd_seq got extra addr %0d exp none", tag, readBuffAddress);
      end else begin
        logic [A-1:0] ea;
        ea = exp_q.pop_front();
        if (readBuffAddress !== ea) begin n_fail++; $display("FAIL %s rd_seq got %0d exp %0d", tag, readBuffAddress, ea); end
      end
    end
    last_done = (done === 1'b1);
    last_rg   = (rdGrant === 1'b1);
    last_wg   = (wrGrant === 1'b1);
    @(posedge CLK);
    case (m_ph)
      PH_IDLE: if (s) begin
        if (rl > DEPTH || wl > DEPTH) m_cfg = 1;
        else begin
          m_nl = nl; m_rl = rl; m_wl = wl; m_rc = 0; m_wc = 0; m_layer = 0;
          m_sel = 0; m_cfg = 0; m_ovf = 0;
          m_ph = (nl == 0) ? PH_DONE : PH_RUN;
        end
      end
      PH_RUN: begin
        if (e_rg) m_rc++;
        if (e_wg) m_wc++;
        if (we && !e_wg) m_ovf = 1;
        if (m_rc == m_rl && m_wc == m_wl) m_ph = PH_SWAP;
      end
      PH_SWAP: begin
        m_sel = ~m_sel; m_rc = 0; m_wc = 0;
        if (m_layer == m_nl - 1) m_ph = PH_DONE;
        else begin m_layer++; m_ph = PH_RUN; end
      end
      default: m_ph = PH_IDLE;
    endcase
    @(negedge CLK);
  endtask

  // Start a run and drive random traffic until the model returns to idle.
  task automatic do_run(input int nl, input int rl, input int wl, input int rq_pct,
                        input int we_pct, input int budget, input string tag, output int dones);
    int k;
    dones = 0; k = 0;
    cycle(1, nl, rl, wl, 0, 0, tag);
    while (m_ph != PH_IDLE && k < budget) begin
      cycle(0, 0, 0, 0, $urandom_range(99) < rq_pct, $urandom_range(99) < we_pct, tag);
      if (last_done) dones++;
      k++;
    end
    n_tests++;
    if (m_ph != PH_IDLE) begin n_fail++; $display("FAIL %s timeout got busy after %0d cycles exp idle", tag, k); end
  endtask

  task automatic test_reset();
    RST = 1; start = 0; numLayers = 0; readLen = 0; writeLen = 0; readReq = 0; writeEn = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 0;
    cycle(0, 0, 0, 0, 0, 0, "reset_idle");
    cycle(1, 1, 5, 5, 0, 0, "reset_start");
    cycle(0, 0, 0, 0, 1, 0, "reset_rd0");
    cycle(0, 0, 0, 0, 1, 0, "reset_rd1");
    n_tests++; if (readBuffAddress !== 7'd2) begin n_fail++; $display("FAIL reset_pre readBuffAddress got %0d exp 2", readBuffAddress); end
    RST = 1;
    #1;
    model_reset();
    n_tests++;
    if ({rdGrant, wrGrant, readBuffAddress, writeBuffAddress, readBufferSelect, layerIdx,
         busy, done, cfgErr, wrOverflow} !== '0) begin
      n_fail++; $display("FAIL reset_async outputs got nonzero (busy=%0b ra=%0d) exp all 0", busy, readBuffAddress);
    end
    @(negedge CLK);
    RST = 0;
    cycle(0, 0, 0, 0, 1, 1, "reset_after");
    n_tests++; if (o_dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", o_dbg_state); end
  endtask

  task automatic test_single_layer();
    int rg, wg;
    rg = 0; wg = 0;
    cycle(1, 1, 3, 2, 0, 0, "single_start");
    for (int k = 1; k <= 12 && m_ph != PH_IDLE; k++) begin
      cycle(0, 0, 0, 0, 1, (k == 2 || k == 4), "single");
      rg += int'(last_rg); wg += int'(last_wg);
    end
    n_tests++; if (rg != 3) begin n_fail++; $display("FAIL single_rd_grants got %0d exp 3", rg); end
    n_tests++; if (wg != 2) begin n_fail++; $display("FAIL single_wr_grants got %0d exp 2", wg); end
    n_tests++; if (readBufferSelect !== 1'b1) begin n_fail++; $display("FAIL single_sel got %0b exp 1", readBufferSelect); end
  endtask

  task automatic test_two_layers();
    int dones;
    do_run(2, 4, 4, 70, 60, 200, "two_layers", dones);
    n_tests++; if (dones != 1) begin n_fail++; $display("FAIL two_layers_dones got %0d exp 1", dones); end
    n_tests++; if (readBufferSelect !== 1'b0) begin n_fail++; $display("FAIL two_layers_sel got %0b exp 0", readBufferSelect); end
    n_tests++; if (layerIdx !== 4'd1) begin n_fail++; $display("FAIL two_layers_layer got %0d exp 1", layerIdx); end
  endtask

  task automatic test_overflow();
    cycle(1, 1, 2, 1, 0, 0, "ovf_start");
    cycle(0, 0, 0, 0, 1, 1, "ovf_w1");
    cycle(0, 0, 0, 0, 0, 1, "ovf_w2");
    n_tests++; if (wrOverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b exp 1", wrOverflow); end
    cycle(0, 0, 0, 0, 1, 0, "ovf_r2");
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 1, 0, "ovf_exhaust");
    n_tests++; if (wrOverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b exp 1", wrOverflow); end
  endtask

  task automatic test_corners();
    int dones;
    do_run(0, 3, 3, 50, 50, 10, "zero_layers", dones);
    n_tests++; if (dones != 1) begin n_fail++; $display("FAIL zero_layers_dones got %0d exp 1", dones); end
    n_tests++; if (readBufferSelect !== 1'b0) begin n_fail++; $display("FAIL zero_layers_sel got %0b exp 0", readBufferSelect); end
    do_run(1, 0, 0, 50, 50, 10, "zero_len", dones);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(A'(i));
    track_rd = 1;
    do_run(1, DEPTH, 0, 100, 0, 400, "full_depth", dones);
    track_rd = 0;
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_depth_left got %0d exp 0", exp_q.size()); end
    n_tests++; if (cfgErr !== 1'b0) begin n_fail++; $display("FAIL full_depth_cfg got %0b exp 0", cfgErr); end
    exp_q.delete();
    do_run(1, DEPTH + 1, 2, 50, 50, 10, "cfg_err", dones);
    n_tests++; if (cfgErr !== 1'b1) begin n_fail++; $display("FAIL cfg_err_flag got %0b exp 1", cfgErr); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cfg_err_busy got %0b exp 0", busy); end
  endtask

  task automatic test_start_while_busy();
    int rg;
    rg = 0;
    cycle(1, 1, 4, 4, 0, 0, "busy_start");
    cycle(0, 0, 0, 0, 1, 0, "busy_rd");
    rg += int'(last_rg);
    cycle(1, 3, 9, 9, 1, 1, "busy_restart");
    rg += int'(last_rg);
    for (int k = 0; k < 40 && m_ph != PH_IDLE; k++) begin
      cycle(0, 0, 0, 0, 1, 1, "busy_run");
      rg += int'(last_rg);
    end
    n_tests++; if (rg != 4) begin n_fail++; $display("FAIL busy_rd_total got %0d exp 4", rg); end
  endtask

  task automatic test_random();
    int dones, nl, rl, wl;
    for (int r = 0; r < 8; r++) begin
      nl = $urandom_range(3);
      rl = ($urandom_range(9) == 0) ? DEPTH + 1 : $urandom_range(10);
      wl = $urandom_range(10);
      do_run(nl, rl, wl, $urandom_range(30, 100), $urandom_range(30, 100), 500, "random", dones);
      n_tests++;
      if (dones != ((rl > DEPTH) ? 0 : 1)) begin n_fail++; $display("FAIL random_dones got %0d exp %0d", dones, (rl > DEPTH) ? 0 : 1); end
    end
  endtask

  initial begin
    test_reset();
    test_single_layer();
    test_two_layers();
    test_overflow();
    test_corners();
    test_start_while_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end

endmodule
